mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the SOC's single-port RAM between the CPU instruction-fetch port (I, read-only)
//   and the load/store port (D, read/write). Round-robin arbitration, one outstanding
//   transaction at a time, fixed-latency memory.
//   Sits between the RV32I core and the RAM/IO memory map inside SOC.
// PARAMETERS
//   ADDR_W      24  byte-address width of both requester ports
//   RD_LATENCY  1   cycles from mem_rstrb cycle to mem_rdata valid (>=1)
// PORTS
//   CLK        in   1         system clock, rising edge
//   RESET      in   1         asynchronous, active-low reset
//   i_req      in   1         fetch request; held high until i_ack
//   i_addr     in   ADDR_W    fetch byte address; stable while i_req high
//   i_ack      out  1         one-cycle pulse; i_rdata valid this cycle
//   i_rdata    out  32        fetch data
//   d_req      in   1         load/store request; held high until d_ack
//   d_addr     in   ADDR_W    load/store byte address
//   d_wdata    in   32        store data
//   d_wmask    in   4         byte write enables; 4'b0000 = read
//   d_ack      out  1         one-cycle pulse; d_rdata valid this cycle if read
//   d_rdata    out  32        load data
//   mem_addr   out  ADDR_W-2  word address to RAM = captured addr[ADDR_W-1:2]
//   mem_wdata  out  32        write data to RAM
//   mem_wmask  out  4         byte write strobes, asserted one cycle
//   mem_rstrb  out  1         read strobe, asserted one cycle
//   mem_rdata  in   32        RAM read data, valid RD_LATENCY cycles after mem_rstrb
// BEHAVIOUR
//   - States: IDLE, ISSUE, WAIT, ACK. Reset (RESET=0, async) -> IDLE; all outputs 0;
//     rr pointer favours I; wait counter 0.
//   - IDLE: no req -> stay. Any req -> ISSUE; grant chosen, addr/wdata/wmask captured.
//   - Arbitration: single req wins. Both -> the port not granted last. First tie after
//     reset -> I.
//   - ISSUE (1 cycle): registered mem_addr valid.
//     - Read: mem_rstrb=1, mem_wmask=0 -> WAIT.
//     - Write (D, wmask!=0): mem_wmask=captured mask, mem_wdata=captured data,
//       mem_rstrb=0 -> ACK.
//   - WAIT: counts RD_LATENCY-1 cycles (0 cycles when RD_LATENCY=1), then -> ACK.
//   - ACK (1 cycle): granted port's ack=1. For a read, its rdata = mem_rdata
//     (pass-through, this cycle only). The other port's ack=0 and rdata=0.
//   - Exit from ACK: if the OTHER port's req is high -> ISSUE directly for it, no IDLE
//     bubble. The just-acked port's req is ignored this cycle even if still high.
//     Otherwise -> IDLE.
//   - Timing: req seen at edge k -> ISSUE cycle k+1.
//     - Read ack in cycle k+1+RD_LATENCY.
//     - Write ack in cycle k+2.
//   - Throughput: RD_LATENCY+1 cycles per read, 2 per write, under continuous
//     alternating load.
//   - mem_addr/mem_wdata hold last value outside ISSUE. mem_wmask and mem_rstrb are 0
//     outside ISSUE.
//   - Never more than one ack per cycle; never both mem_rstrb and nonzero mem_wmask.
//   - i_addr[1:0], d_addr[1:0] ignored (word-aligned access).
//   - Req dropped before ack: protocol violation; the transaction still completes and acks.
//   - Reset mid-transaction: immediate return to IDLE; no ack issued for the aborted
//     request.
// TESTING
//   1 I read: RAM[word 4]=32'hDEADBEEF; i_req=1, i_addr=24'h10 seen edge 0
//     -> cycle 1 mem_rstrb=1, mem_addr=4; cycle 2 i_ack=1, i_rdata=32'hDEADBEEF.
//   2 Tie after reset: i_req, d_req (read 0x20) both seen edge 0
//     -> i_ack cycle 2, ISSUE for D cycle 3, d_ack cycle 4.
//   3 D write: d_addr=24'h20, d_wdata=32'h1234ABCD, d_wmask=4'b0011
//     -> cycle 1 mem_wmask=0011, mem_addr=8; cycle 2 d_ack=1, i_ack=0.
//     Read back gives 32'hxxxxABCD, upper bytes unchanged.
//   4 Both reqs held for 8 transactions -> grants strictly I,D,I,D,...
//     Acks every 2 cycles; never i_ack&d_ack.
//   5 RD_LATENCY=3, single I read seen edge 0 -> mem_rstrb cycle 1, i_ack cycle 4 only.
//   6 RESET=0 in WAIT (RD_LATENCY=3) -> all outputs 0 same cycle.
//     After release, no ack until a new req.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester/RAM bundle for mem_port_arbiter: fetch port (I), load/store port (D), RAM port.
// slave is the arbiter's view; master is the requester/RAM side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 24
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wmask;
    logic              d_ack;
    logic [31:0]       d_rdata;

    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_rstrb;
    logic [31:0]       mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rdata,
        input  d_req, d_addr, d_wdata, d_wmask,
        output d_ack, d_rdata,
        output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_ack, i_rdata,
        output d_req, d_addr, d_wdata, d_wmask,
        input  d_ack, d_rdata,
        input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port RAM between the instruction-fetch
// port (read-only) and the load/store port; one transaction outstanding at a time.
module mem_port_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int RD_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    // WAIT lasts RD_LATENCY-1 cycles; the counter is loaded with RD_LATENCY-2 and exits at zero.
    localparam int               CNT_W     = (RD_LATENCY > 3) ? $clog2(RD_LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = (RD_LATENCY > 1) ? CNT_W'(RD_LATENCY - 2) : '0;

    logic [1:0]        state_q,     state_d;
    logic              gnt_d_q,     gnt_d_d;
    logic              prio_d_q,    prio_d_d;
    logic              is_wr_q,     is_wr_d;
    logic [3:0]        wmask_q,     wmask_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [ADDR_W-3:0] mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic start;
    logic sel_d;
    logic sel_wr;
    logic in_ack;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

    always_comb begin
        state_d     = state_q;
        gnt_d_d     = gnt_d_q;
        prio_d_d    = prio_d_q;
        is_wr_d     = is_wr_q;
        wmask_d     = wmask_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        start       = 1'b0;
        sel_d       = 1'b0;
        sel_wr      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    start = 1'b1;
                    sel_d = bus.d_req && (!bus.i_req || prio_d_q);
                end
            end
            S_ISSUE: begin
                if (is_wr_q || RD_LATENCY == 1) begin
                    state_d = S_ACK;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_ACK;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_ACK: begin
                // Only the other port may chain straight into ISSUE; the acked port's req is stale.
                state_d = S_IDLE;
                if (gnt_d_q ? bus.i_req : bus.d_req) begin
                    start = 1'b1;
                    sel_d = !gnt_d_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            sel_wr     = sel_d && (bus.d_wmask != 4'b0000);
            state_d    = S_ISSUE;
            gnt_d_d    = sel_d;
            prio_d_d   = !sel_d;
            is_wr_d    = sel_wr;
            wmask_d    = sel_wr ? bus.d_wmask : '0;
            mem_addr_d = sel_d ? bus.d_addr[ADDR_W-1:2] : bus.i_addr[ADDR_W-1:2];
            if (sel_wr) mem_wdata_d = bus.d_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            gnt_d_q     <= 1'b0;
            prio_d_q    <= 1'b0;
            is_wr_q     <= 1'b0;
            wmask_q     <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_d_q     <= gnt_d_d;
            prio_d_q    <= prio_d_d;
            is_wr_q     <= is_wr_d;
            wmask_q     <= wmask_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign in_ack = (state_q == S_ACK);

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wmask = (state_q == S_ISSUE) ? wmask_q : '0;
    assign bus.mem_rstrb = (state_q == S_ISSUE) && !is_wr_q;

    assign bus.i_ack   = in_ack && !gnt_d_q;
    assign bus.d_ack   = in_ack && gnt_d_q;
    assign bus.i_rdata = (in_ack && !gnt_d_q) ? bus.mem_rdata : '0;
    assign bus.d_rdata = (in_ack && gnt_d_q && !is_wr_q) ? bus.mem_rdata : '0;

endmodule
